// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared RV32I decode encodings; DECODE_RV32M_EN enables the M extension.
package decode_stage_pkg;
`ifdef DECODE_RV32M_EN
  localparam int ALU_W = 5;
  localparam bit M_EN = 1'b1;
`else
  localparam int ALU_W = 4;
  localparam bit M_EN = 1'b0;
`endif
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_MISC   = 7'h0f,
    OPC_OPIMM  = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6f,
    OPC_SYSTEM = 7'h73
  } opcode_e;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SR  = 3'd5;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MUL  = 7'h01;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [2:0] MEM_RD_NONE = 3'b111;
  localparam logic [1:0] MEM_WR_NONE = 2'b11;
  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;
  typedef struct packed {
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             reg_wen;
    logic             sel_imm;
    logic             sel_pc;
    logic [ALU_W-1:0] alu_op;
    logic [2:0]       mem_rd_op;
    logic [1:0]       mem_wr_op;
    logic [3:0]       br_op;
    logic [1:0]       jump;
    logic             ill;
  } dec_ctrl_t;
  localparam dec_ctrl_t CTRL_RST = '{mem_rd_op: MEM_RD_NONE, mem_wr_op: MEM_WR_NONE, default: '0};
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32, parameter int IMM_WIDTH = 32);
  logic                             in_valid;
  logic                             in_ready;
  logic [XLEN-1:0]                  in_instr;
  logic [XLEN-1:0]                  in_pc;
  logic                             out_valid;
  logic                             out_ready;
  logic [XLEN-1:0]                  out_pc;
  logic [4:0]                       out_rd;
  logic [4:0]                       out_rs1;
  logic [4:0]                       out_rs2;
  logic                             out_reg_wen;
  logic                             out_sel_imm;
  logic                             out_sel_pc;
  logic [decode_stage_pkg::ALU_W-1:0] out_alu_op;
  logic [2:0]                       out_mem_rd_op;
  logic [1:0]                       out_mem_wr_op;
  logic [3:0]                       out_br_op;
  logic [1:0]                       out_jump;
  logic [IMM_WIDTH-1:0]             out_imm;
  logic                             out_ill_instr;
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_reg_wen, out_sel_imm,
           out_sel_pc, out_alu_op, out_mem_rd_op, out_mem_wr_op, out_br_op, out_jump, out_imm,
           out_ill_instr
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_reg_wen, out_sel_imm,
           out_sel_pc, out_alu_op, out_mem_rd_op, out_mem_wr_op, out_br_op, out_jump, out_imm,
           out_ill_instr
  );
endinterface

// File: rtl/decode_stage_logic.sv
// decode_logic: combinational RV32I instruction word to control bundle and immediate.
module decode_logic
  import decode_stage_pkg::*;
#(parameter int IMM_WIDTH = 32) (
  input  logic [31:0]          instr,
  output dec_ctrl_t            ctrl,
  output logic [IMM_WIDTH-1:0] imm
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  assign opc = instr[OPC_LSB +: 7];
  assign f3 = instr[F3_LSB +: 3];
  assign f7 = instr[F7_LSB +: 7];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm = IMM_WIDTH'($signed(imm32));
  always_comb begin
    ctrl = CTRL_RST;
    ctrl.rd = instr[RD_LSB +: 5];
    ctrl.rs1 = instr[RS1_LSB +: 5];
    ctrl.rs2 = instr[RS2_LSB +: 5];
    imm32 = '0;
    case (opc)
      OPC_OP: begin
        ctrl.reg_wen = 1'b1;
        ctrl.alu_op = ALU_W'({f7 == F7_MUL, f7[5], f3});
        ctrl.ill = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) || (M_EN && f7 == F7_MUL));
      end
      OPC_OPIMM: begin
        ctrl.reg_wen = 1'b1;
        ctrl.sel_imm = 1'b1;
        imm32 = imm_i;
        // only shifts carry an opcode bit in func7; elsewhere those bits are immediate
        ctrl.alu_op = ALU_W'({f3 == F3_SR && f7[5], f3});
        ctrl.ill = (f3 == F3_SLL && f7 != F7_BASE) || (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
      end
      OPC_LOAD: begin
        ctrl.reg_wen = 1'b1;
        ctrl.sel_imm = 1'b1;
        imm32 = imm_i;
        ctrl.mem_rd_op = f3;
        ctrl.ill = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        ctrl.sel_imm = 1'b1;
        imm32 = imm_s;
        ctrl.mem_wr_op = f3[1:0];
        ctrl.ill = f3 >= 3'd3;
      end
      OPC_BRANCH: begin
        imm32 = imm_b;
        ctrl.br_op = {1'b1, f3};
        ctrl.ill = f3[2:1] == 2'b01;
      end
      OPC_JAL: begin
        ctrl.reg_wen = 1'b1;
        ctrl.sel_imm = 1'b1;
        ctrl.sel_pc = 1'b1;
        imm32 = imm_j;
        ctrl.jump = JMP_JAL;
      end
      OPC_JALR: begin
        ctrl.reg_wen = 1'b1;
        ctrl.sel_imm = 1'b1;
        imm32 = imm_i;
        ctrl.jump = JMP_JALR;
        ctrl.ill = f3 != F3_ADD;
      end
      OPC_LUI: begin
        ctrl.reg_wen = 1'b1;
        ctrl.sel_imm = 1'b1;
        ctrl.rs1 = '0;
        imm32 = imm_u;
      end
      OPC_AUIPC: begin
        ctrl.reg_wen = 1'b1;
        ctrl.sel_imm = 1'b1;
        ctrl.sel_pc = 1'b1;
        imm32 = imm_u;
      end
      OPC_MISC: imm32 = imm_i;
      OPC_SYSTEM: begin
        imm32 = imm_i;
        ctrl.ill = !(instr == INSTR_ECALL || instr == INSTR_EBREAK);
      end
      default: ctrl.ill = 1'b1;
    endcase
    if (ctrl.ill) begin
      ctrl.reg_wen = 1'b0;
      ctrl.mem_rd_op = MEM_RD_NONE;
      ctrl.mem_wr_op = MEM_WR_NONE;
      ctrl.br_op = '0;
      ctrl.jump = JMP_NONE;
    end
    if (ctrl.rd == '0) ctrl.reg_wen = 1'b0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with two-entry skid buffer and flush; DECODE_RV32M_EN adds RV32M.
module decode_stage
  import decode_stage_pkg::*;
#(parameter int XLEN = 32, parameter int IMM_WIDTH = 32) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  decode_stage_if.slave bus
);
  buf_state_e state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic in_fire, out_fire, load_out, skid_load;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d, pc_q, pc_d, sel_instr;
  dec_ctrl_t ctrl_q, ctrl_d, dec_ctrl;
  logic [IMM_WIDTH-1:0] imm_q, imm_d, dec_imm;
  assign in_fire = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;
  // skid entry keeps the raw word so a single decoder serves both paths
  assign sel_instr = state_q == TWO ? skid_instr_q : bus.in_instr;
  decode_logic #(.IMM_WIDTH(IMM_WIDTH)) u_dec (.instr(sel_instr[31:0]), .ctrl(dec_ctrl), .imm(dec_imm));
  always_comb begin
    skid_load = state_q == ONE && in_fire && !out_fire && !flush;
    load_out = !flush && (state_q == TWO ? out_fire : in_fire && (state_q == EMPTY || out_fire));
    if (flush) state_d = EMPTY;
    else if (state_q == EMPTY) state_d = in_fire ? ONE : EMPTY;
    else if (state_q == ONE) state_d = in_fire == out_fire ? ONE : (in_fire ? TWO : EMPTY);
    else state_d = out_fire ? ONE : TWO;
    ctrl_d = load_out ? dec_ctrl : ctrl_q;
    imm_d = load_out ? dec_imm : imm_q;
    pc_d = load_out ? (state_q == TWO ? skid_pc_q : bus.in_pc) : pc_q;
    skid_instr_d = skid_load ? bus.in_instr : skid_instr_q;
    skid_pc_d = skid_load ? bus.in_pc : skid_pc_q;
    in_ready_d = state_d != TWO;
    out_valid_d = state_d != EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      ctrl_q <= CTRL_RST;
      imm_q <= '0;
      pc_q <= '0;
      skid_instr_q <= '0;
      skid_pc_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      ctrl_q <= ctrl_d;
      imm_q <= imm_d;
      pc_q <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q <= skid_pc_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc = pc_q;
  assign bus.out_rd = ctrl_q.rd;
  assign bus.out_rs1 = ctrl_q.rs1;
  assign bus.out_rs2 = ctrl_q.rs2;
  assign bus.out_reg_wen = ctrl_q.reg_wen;
  assign bus.out_sel_imm = ctrl_q.sel_imm;
  assign bus.out_sel_pc = ctrl_q.sel_pc;
  assign bus.out_alu_op = ctrl_q.alu_op;
  assign bus.out_mem_rd_op = ctrl_q.mem_rd_op;
  assign bus.out_mem_wr_op = ctrl_q.mem_wr_op;
  assign bus.out_br_op = ctrl_q.br_op;
  assign bus.out_jump = ctrl_q.jump;
  assign bus.out_imm = imm_q;
  assign bus.out_ill_instr = ctrl_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboarded random and directed test of decode_stage against a reference decoder.
module tb_decode_stage;
  import decode_stage_pkg::*;
  typedef struct packed {
    logic [31:0]      pc;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             wen;
    logic             sel_imm;
    logic             sel_pc;
    logic [ALU_W-1:0] alu;
    logic [2:0]       mrd;
    logic [1:0]       mwr;
    logic [3:0]       br;
    logic [1:0]       jmp;
    logic [31:0]      imm;
    logic             ill;
  } bundle_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  int n_chk = 0, n_fail = 0;
  bundle_t q[$];
  always #5 clk = ~clk;
  decode_stage_if #(.XLEN(32), .IMM_WIDTH(32)) bus();
  decode_stage #(.XLEN(32), .IMM_WIDTH(32)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
    bundle_t e;
    int s, f3, f7;
    s = int'(i);
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    e = '0;
    e.pc = pc;
    e.rd = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.mrd = 3'd7;
    e.mwr = 2'd3;
    case (i[6:0])
      7'h33: begin
        e.wen = 1'b1;
        e.alu = ALU_W'(((M_EN && f7 == 1) ? 16 : 0) + ((f7 >> 5) % 2) * 8 + f3);
        e.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)) || (M_EN && f7 == 1));
      end
      7'h13: begin
        e.wen = 1'b1; e.sel_imm = 1'b1; e.imm = s >>> 20;
        e.alu = ALU_W'(f3 + (f3 == 5 ? ((f7 >> 5) % 2) * 8 : 0));
        e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
      end
      7'h03: begin
        e.wen = 1'b1; e.sel_imm = 1'b1; e.imm = s >>> 20; e.mrd = 3'(f3);
        e.ill = f3 == 3 || f3 == 6 || f3 == 7;
      end
      7'h23: begin
        e.sel_imm = 1'b1; e.imm = (s >>> 25) * 32 + int'(i[11:7]); e.mwr = 2'(f3);
        e.ill = f3 >= 3;
      end
      7'h63: begin
        e.imm = (s >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        e.br = 4'(8 + f3);
        e.ill = f3 == 2 || f3 == 3;
      end
      7'h6f: begin
        e.wen = 1'b1; e.sel_imm = 1'b1; e.sel_pc = 1'b1; e.jmp = 2'd1;
        e.imm = (s >>> 31) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      end
      7'h67: begin
        e.wen = 1'b1; e.sel_imm = 1'b1; e.imm = s >>> 20; e.jmp = 2'd2; e.ill = f3 != 0;
      end
      7'h37: begin
        e.wen = 1'b1; e.sel_imm = 1'b1; e.rs1 = 5'd0; e.imm = i & 32'hFFFF_F000;
      end
      7'h17: begin
        e.wen = 1'b1; e.sel_imm = 1'b1; e.sel_pc = 1'b1; e.imm = i & 32'hFFFF_F000;
      end
      7'h0f: e.imm = s >>> 20;
      7'h73: begin
        e.imm = s >>> 20;
        e.ill = !(i == 32'h0000_0073 || i == 32'h0010_0073);
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.wen = 1'b0; e.mrd = 3'd7; e.mwr = 2'd3; e.br = 4'd0; e.jmp = 2'd0;
    end
    if (e.rd == 5'd0) e.wen = 1'b0;
    return e;
  endfunction

  function automatic bundle_t observe();
    bundle_t b;
    b.pc = bus.out_pc; b.rd = bus.out_rd; b.rs1 = bus.out_rs1; b.rs2 = bus.out_rs2;
    b.wen = bus.out_reg_wen; b.sel_imm = bus.out_sel_imm; b.sel_pc = bus.out_sel_pc;
    b.alu = bus.out_alu_op; b.mrd = bus.out_mem_rd_op; b.mwr = bus.out_mem_wr_op;
    b.br = bus.out_br_op; b.jmp = bus.out_jump; b.imm = bus.out_imm; b.ill = bus.out_ill_instr;
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6f, 7'h73};
    logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'h01};
    logic [31:0] r;
    int k;
    r = $urandom;
    k = int'($urandom_range(0, 13));
    if (k < 11) r[6:0] = ops[k];
    if (r[6:0] == 7'h33 && $urandom_range(0, 3) != 0) r[31:25] = f7s[$urandom_range(0, 2)];
    if (r[6:0] == 7'h73 && $urandom_range(0, 1) != 0) r = $urandom_range(0, 1) != 0 ? 32'h0010_0073 : 32'h0000_0073;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", bus.out_valid, q.size() != 0);
      check("in_ready", bus.in_ready, q.size() < 2);
      if (bus.out_valid && q.size() != 0) begin
        check("bundle", observe(), q[0]);
        if (bus.out_ready) void'(q.pop_front());
      end
      if (flush) q.delete();
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl, output logic acc);
    logic [31:0] pc;
    pc = $urandom;
    @(posedge clk); #1;
    bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = rdy; flush = fl;
    @(negedge clk); #1;
    acc = v && bus.in_ready;
    if (acc && !fl) q.push_back(model(ins, pc));
  endtask

  task automatic do_reset(input logic v);
    bundle_t rb;
    rb = '0; rb.mrd = 3'd7; rb.mwr = 2'd3;
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; bus.in_valid = v; bus.in_instr = $urandom; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_bundle", observe(), rb);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    logic acc;
    logic [31:0] dir [23] = '{32'h00500093, 32'h0020A423, 32'h00000000, 32'h00002063, 32'h022081B3,
                              32'h00000073, 32'h00100073, 32'h30200073, 32'h123452B7, 32'h00001097,
                              32'h008000EF, 32'h000080E7, 32'h4010D093, 32'h6010D093, 32'h0000B083,
                              32'h0FF0000F, 32'h40208033, 32'h40209033, 32'hFFF10113, 32'hFE20AE23,
                              32'hFE000EE3, 32'h00000013, 32'h00000001};
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    do_reset(1'b0);
    foreach (dir[k]) drive(1'b1, dir[k], 1'b1, 1'b0, acc);
    repeat (2) drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
    drive(1'b1, 32'h00500093, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h0020A423, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h022081B3, 1'b0, 1'b0, acc);
    check("c_held", acc, 1'b0);
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) drive(1'b1, 32'h022081B3, 1'b1, 1'b0, acc);
    check("c_accepted", acc, 1'b1);
    repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
    drive(1'b1, 32'h00500093, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h0020A423, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h123452B7, 1'b0, 1'b1, acc);
    drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
    drive(1'b1, 32'h00500093, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h008000EF, 1'b1, 1'b1, acc);
    drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
    drive(1'b1, 32'h00500093, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h0020A423, 1'b0, 1'b0, acc);
    do_reset(1'b1);
    for (int n = 0; n < 3000; n++)
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, acc);
    repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked RV32I instruction-decode stage that generalises the core's combinational decoder. It covers every RV32I base opcode (OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC-MEM, SYSTEM) and has a parametrised immediate width. It sits between the fetch stage and the execute stage. A two-entry skid buffer lets fetch run at full throughput while execute stalls, and a flush input squashes in-flight instructions on a taken branch or trap.

## Interface
Parameters:
- XLEN, 32, data and PC width
- IMM_WIDTH, 32, width of the sign-extended immediate output; legal range 20..XLEN

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  squash all held and incoming instructions this cycle
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept an instruction
- in_instr  in  XLEN  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  XLEN  PC of the decoded instruction
- out_rd, out_rs1, out_rs2  out  5 each  register addresses
- out_reg_wen  out  1  instruction writes rd; forced 0 when rd==0
- out_sel_imm  out  1  ALU operand B is the immediate
- out_sel_pc  out  1  ALU operand A is the PC (AUIPC, JAL)
- out_alu_op  out  4  ALU op, encoded as {func7[5], func3}; LUI encodes as ADD with rs1 forced to 0
- out_mem_rd_op  out  3  load func3; 3'b111 means no read
- out_mem_wr_op  out  2  store size; 2'b11 means no write
- out_br_op  out  4  {is_branch, func3}
- out_jump  out  2  00 none, 01 JAL, 10 JALR
- out_imm  out  IMM_WIDTH  sign-extended immediate (I/S/B/U/J format per opcode)
- out_ill_instr  out  1  illegal instruction

## Operation
- Decode logic is combinational on the selected input word. Results are captured into the output register on acceptance.
- Handshake: a transfer occurs on each side when valid && ready in the same cycle.
- Buffer states:
  - EMPTY: out_valid=0.
  - ONE: output register holds a bundle.
  - TWO: output register plus skid entry are full.
- State transitions:
  - EMPTY, in accepted → ONE.
  - ONE, in accepted with no out transfer → TWO.
  - ONE, in accepted with an out transfer → ONE (new bundle loaded).
  - ONE, out transfer only → EMPTY.
  - TWO, out transfer → ONE (skid entry moves to the output register).
- in_ready = (state != TWO). It is registered, so it never depends combinationally on out_ready.
- Illegal-instruction conditions:
  - Unknown opcode.
  - instr[1:0] != 2'b11.
  - LOAD func3 ∈ {3,6,7}; STORE func3 ≥ 3.
  - BRANCH func3 ∈ {2,3}.
  - OP with func7 not in {0x00, 0x20}, or 0x20 with func3 not in {0,5}.
  - OP-IMM shift with a bad func7.
  - JALR func3 != 0.
- An illegal bundle still flows downstream with reg_wen=0, mem ops set to none, jump=0, br_op[3]=0, and ill_instr=1.
- MISC-MEM (FENCE) decodes as a NOP. SYSTEM ECALL/EBREAK decode as NOPs with ill_instr=0; any other SYSTEM encoding is illegal unless handled downstream.
- Immediate formats (before extension to IMM_WIDTH by replicating instr[31]):
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}, truncated to IMM_WIDTH
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}

## Timing
- Latency: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1.
- Throughput: 1 instruction/cycle while out_ready=1.
- Reset (rst=1 at a clk edge) → state EMPTY, out_valid=0, in_ready=1, and every data output 0, except:
  - out_mem_rd_op=3'b111
  - out_mem_wr_op=2'b11
- Flush:
  - Takes effect at the next edge: state → EMPTY, out_valid=0, in_ready=1.
  - An in_valid presented in the same cycle as flush is dropped.
  - flush has priority over simultaneous in/out transfers.
  - The out transfer in the flush cycle still counts: execute owns the kill.
- rst has priority over flush.
- Bundle contents are stable while out_valid && !out_ready.

## Configuration
- DECODE_RV32M_EN defined:
  - OP with func7=0x01 is legal.
  - out_alu_op is widened to 5 bits, with bit 4 = M-extension; func3 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- DECODE_RV32M_EN undefined:
  - out_alu_op is 4 bits.
  - func7=0x01 is illegal.

## Structure
- Shared package holds:
  - opcode constants
  - func3/func7 values
  - ALU, mem, branch and jump op encodings and the no-op sentinels
  - instruction field ranges
- Sub-module decode_logic is purely combinational, mapping instruction → bundle. decode_stage adds the skid buffer, handshake and flush around it.

## Test plan
- addi x1,x0,5 (0x00500093), out_ready=1 → next cycle: out_valid=1, rd=1, rs1=0, imm=5, reg_wen=1, sel_imm=1, alu_op=0.
- sw x2,8(x1) (0x0020A423) → imm=8, mem_wr_op=2'b10, reg_wen=0, mem_rd_op=3'b111.
- Back-to-back instrs A, B, C with out_ready held 0 for 3 cycles → in_ready falls after A and B are accepted; C is held by fetch; release gives output order A, B, C with no loss or duplication.
- 0x00000000 and beq func3=2 (0x00002063) → ill_instr=1, reg_wen=0.
- mul x3,x1,x2 (0x022081B3) → legal with alu_op=5'b10000 when DECODE_RV32M_EN is defined; ill_instr=1 when it is not.
- State TWO plus flush and in_valid in the same cycle → next cycle: out_valid=0, in_ready=1, incoming instruction dropped; rst mid-stall gives the reset values.
